envolve_logic: RTL and testbench

- Conway's Game of Life engine holding a 64x64 single-bit cell grid.
- A host such as the display/VGA scanner or an edit controller reads cells by row/column.
- The host writes individual cells to seed patterns.
- A change_state strobe advances the whole grid by exactly one generation in a single clock.

---
 rtl/envolve_logic.sv | 63 ++++++
 tb/tb_envolve_logic.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envolve_logic.sv
// Game of Life engine: 64x64 cell grid with random-access cell
// read/write and a one-clock, edge-triggered generation step.
module envolve_logic (
   input  logic       clk,
   input  logic       rst,
   input  logic       write_en,
   input  logic       change_state,
   input  logic [5:0] rAddrR,
   input  logic [5:0] rAddrC,
   input  logic [5:0] wAddrR,
   input  logic [5:0] wAddrC,
   input  logic       write_data,
   output logic       read_data
);

   logic [63:0]   grid [64];
   logic [65:0]   pad  [66];
   logic [4095:0] nxt;
   logic          prev_cs;
   logic          evolve;

   assign evolve    = change_state & ~prev_cs;
   assign read_data = grid[rAddrR][rAddrC];

   // A ring of dead cells around the grid keeps every neighbourhood 3x3
   assign pad[0]  = '0;
   assign pad[65] = '0;

   for (genvar gr = 0; gr < 64; gr++) begin : g_pad
      assign pad[gr+1] = {1'b0, grid[gr], 1'b0};
   end

   for (genvar gr = 0; gr < 64; gr++) begin : g_row
      for (genvar gc = 0; gc < 64; gc++) begin : g_col
         logic [3:0] n;
         assign n = 4'(pad[gr][gc])     + 4'(pad[gr][gc+1])
                  + 4'(pad[gr][gc+2])   + 4'(pad[gr+1][gc])
                  + 4'(pad[gr+1][gc+2]) + 4'(pad[gr+2][gc])
                  + 4'(pad[gr+2][gc+1]) + 4'(pad[gr+2][gc+2]);
         assign nxt[gr*64+gc] = (n == 4'd3)
                              | (grid[gr][gc] & (n == 4'd2));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_cs <= 1'b0;
         for (int r = 0; r < 64; r++) begin
            grid[r] <= '0;
         end
      end else begin
         prev_cs <= change_state;
         if (evolve) begin
            for (int r = 0; r < 64; r++) begin
               grid[r] <= nxt[r*64 +: 64];
            end
         end else if (write_en) begin
            grid[wAddrR][wAddrC] <= write_data;
         end
      end
   end

endmodule

// File: tb/tb_envolve_logic.sv
// Self-checking bench for envolve_logic: directed Life patterns plus
// randomized write/evolve traffic against a behavioural grid model.
module tb_envolve_logic;

   logic       clk;
   logic       rst;
   logic       write_en;
   logic       change_state;
   logic [5:0] rAddrR;
   logic [5:0] rAddrC;
   logic [5:0] wAddrR;
   logic [5:0] wAddrC;
   logic       write_data;
   logic       read_data;

   int total = 0;
   int bad   = 0;

   bit m [64][64];

   envolve_logic dut (
      .clk          (clk),
      .rst          (rst),
      .write_en     (write_en),
      .change_state (change_state),
      .rAddrR       (rAddrR),
      .rAddrC       (rAddrC),
      .wAddrR       (wAddrR),
      .wAddrC       (wAddrC),
      .write_data   (write_data),
      .read_data    (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++)
            m[r][c] = 1'b0;
   endfunction

   function automatic void model_step();
      bit nx [64][64];
      for (int r = 0; r < 64; r++) begin
         for (int c = 0; c < 64; c++) begin
            int n;
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (!(dr == 0 && dc == 0) &&
                      r + dr >= 0 && r + dr < 64 &&
                      c + dc >= 0 && c + dc < 64 &&
                      m[r+dr][c+dc])
                     n++;
            nx[r][c] = m[r][c] ? (n == 2 || n == 3) : (n == 3);
         end
      end
      m = nx;
   endfunction

   task automatic write_cell(input int r, input int c, input bit v);
      wAddrR     = 6'(r);
      wAddrC     = 6'(c);
      write_data = v;
      write_en   = 1'b1;
      tick();
      write_en   = 1'b0;
      m[r][c]    = v;
   endtask

   task automatic evolve_once();
      change_state = 1'b1;
      tick();
      change_state = 1'b0;
      tick();
      model_step();
   endtask

   task automatic check_cell(input string tag, input int r, input int c,
                             input bit exp);
      rAddrR = 6'(r);
      rAddrC = 6'(c);
      #1;
      total++;
      assert (read_data === exp) else begin
         bad++;
         $error("FAIL %s cell(%0d,%0d) observed=%b expected=%b",
                tag, r, c, read_data, exp);
      end
   endtask

   task automatic check_grid(input string tag);
      logic [4095:0] obs;
      logic [4095:0] exp;
      int ndiff;
      int first;
      ndiff = 0;
      first = -1;
      for (int r = 0; r < 64; r++) begin
         for (int c = 0; c < 64; c++) begin
            rAddrR = 6'(r);
            rAddrC = 6'(c);
            #1;
            obs[r*64+c] = read_data;
            exp[r*64+c] = m[r][c];
            if (read_data !== m[r][c]) begin
               ndiff++;
               if (first < 0) first = r*64 + c;
            end
         end
      end
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s grid: %0d cells differ, first (%0d,%0d) observed=%b expected=%b",
                tag, ndiff, first / 64, first % 64,
                obs[first], exp[first]);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b0;
      model_clear();
      check_grid({tag, "_during"});
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_grid({tag, "_after"});
   endtask

   initial begin
      rst          = 1'b0;
      write_en     = 1'b0;
      change_state = 1'b0;
      rAddrR       = '0;
      rAddrC       = '0;
      wAddrR       = '0;
      wAddrC       = '0;
      write_data   = 1'b0;
      model_clear();
      #12;
      rst = 1'b1;
      tick();
      check_grid("reset_init");

      // reset clears written cells asynchronously
      write_cell(3, 4, 1'b1);
      write_cell(63, 63, 1'b1);
      write_cell(0, 0, 1'b1);
      check_grid("pre_reset");
      do_reset("reset");

      // write / read, including read-during-write at the same address
      rAddrR     = 6'd5;
      rAddrC     = 6'd7;
      wAddrR     = 6'd5;
      wAddrC     = 6'd7;
      write_data = 1'b1;
      write_en   = 1'b1;
      #1;
      total++;
      assert (read_data === 1'b0) else begin
         bad++;
         $error("FAIL rw_same_old observed=%b expected=%b", read_data, 1'b0);
      end
      tick();
      write_en = 1'b0;
      m[5][7]  = 1'b1;
      check_cell("rw_same_new", 5, 7, 1'b1);
      write_cell(5, 8, 1'b0);
      check_cell("wr_57", 5, 7, 1'b1);
      check_cell("wr_58", 5, 8, 1'b0);
      check_cell("wr_75", 7, 5, 1'b0);
      check_grid("wr_sweep");
      write_cell(5, 7, 1'b0);
      check_cell("rewrite_57", 5, 7, 1'b0);

      // blinker next to a still-life block
      do_reset("rst_blink");
      write_cell(10, 9, 1'b1);
      write_cell(10, 10, 1'b1);
      write_cell(10, 11, 1'b1);
      write_cell(20, 20, 1'b1);
      write_cell(20, 21, 1'b1);
      write_cell(21, 20, 1'b1);
      write_cell(21, 21, 1'b1);
      evolve_once();
      check_cell("blink_v_top", 9, 10, 1'b1);
      check_cell("blink_v_bot", 11, 10, 1'b1);
      check_cell("blink_v_left", 10, 9, 1'b0);
      check_grid("blink_gen1");
      evolve_once();
      check_cell("blink_h_left", 10, 9, 1'b1);
      check_cell("blink_h_top", 9, 10, 1'b0);
      check_cell("block_hold", 21, 21, 1'b1);
      check_grid("blink_gen2");

      // left edge does not wrap to column 63
      do_reset("rst_edge");
      write_cell(5, 0, 1'b1);
      write_cell(6, 0, 1'b1);
      write_cell(7, 0, 1'b1);
      evolve_once();
      check_cell("edge_60", 6, 0, 1'b1);
      check_cell("edge_61", 6, 1, 1'b1);
      check_cell("edge_50", 5, 0, 1'b0);
      check_cell("edge_663", 6, 63, 1'b0);
      check_grid("edge_gen1");

      do_reset("rst_corner");
      write_cell(0, 0, 1'b1);
      write_cell(0, 1, 1'b1);
      write_cell(1, 0, 1'b1);
      evolve_once();
      check_cell("corner_11", 1, 1, 1'b1);
      check_grid("corner_gen1");

      // a held change_state level gives exactly one step
      do_reset("rst_level");
      write_cell(10, 9, 1'b1);
      write_cell(10, 10, 1'b1);
      write_cell(10, 11, 1'b1);
      change_state = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      model_step();
      check_cell("level_v", 9, 10, 1'b1);
      check_grid("level_hold");
      change_state = 1'b0;
      tick();
      check_grid("level_drop");
      change_state = 1'b1;
      tick();
      model_step();
      check_cell("level_rerise", 10, 9, 1'b1);
      check_grid("level_rerise_grid");
      change_state = 1'b0;
      tick();

      // write colliding with a step is dropped
      do_reset("rst_coll");
      wAddrR       = 6'd30;
      wAddrC       = 6'd30;
      write_data   = 1'b1;
      write_en     = 1'b1;
      change_state = 1'b1;
      tick();
      write_en     = 1'b0;
      change_state = 1'b0;
      model_step();
      check_cell("coll_drop", 30, 30, 1'b0);
      write_cell(30, 30, 1'b1);
      check_cell("coll_write", 30, 30, 1'b1);
      check_grid("coll_grid");

      // randomized soup: dense region writes, then mixed traffic
      do_reset("rst_rand");
      for (int i = 0; i < 700; i++) begin
         int r;
         int c;
         r = (i % 3 == 0) ? int'($urandom_range(0, 63))
                          : int'($urandom_range(20, 40));
         c = (i % 3 == 0) ? int'($urandom_range(0, 63))
                          : int'($urandom_range(20, 40));
         write_cell(r, c, 1'($urandom_range(0, 2) != 0));
      end
      check_grid("rand_seed");
      for (int s = 0; s < 20; s++) begin
         int op;
         op = int'($urandom_range(0, 3));
         if (op == 0) begin
            for (int k = 0; k < 8; k++)
               write_cell(int'($urandom_range(0, 63)),
                          int'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)));
         end else if (op == 1) begin
            wAddrR       = 6'($urandom_range(0, 63));
            wAddrC       = 6'($urandom_range(0, 63));
            write_data   = 1'($urandom_range(0, 1));
            write_en     = 1'b1;
            change_state = 1'b1;
            tick();
            write_en     = 1'b0;
            change_state = 1'b0;
            tick();
            model_step();
         end else begin
            evolve_once();
         end
         check_grid($sformatf("rand_step%0d", s));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
